// File: rtl/adc_pkg.sv
// adc_pkg: shared defaults, gain-unity constant and decimator state for the ADC calibration slice
package adc_pkg;
  localparam int DW_DEF = 14;
  localparam int DEC_MAX_DEF = 8;
  localparam logic [15:0] GAIN_ONE = 16'h8000;
  typedef enum logic {IDLE, ACC} dec_state_e;
endpackage

// File: rtl/adc_dec_avg.sv
// adc_dec_avg: power-of-two window averager fed by the calibrated sample stream
module adc_dec_avg import adc_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int DEC_MAX = DEC_MAX_DEF
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          en_i,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  input  logic [3:0]    log2_i,
  output logic [DW-1:0] dat_o,
  output logic          vld_o
);
  localparam int AW = DW + DEC_MAX;
  dec_state_e state_q;
  logic [3:0] n_q, n_d;
  logic [DEC_MAX-1:0] cnt_q;
  logic signed [AW-1:0] acc_q, smp, sum_d;
  logic [DEC_MAX:0] win;
  logic last;
  logic [DW-1:0] dat_q;
  logic vld_q;
  always_comb begin
    n_d = log2_i > 4'(DEC_MAX) ? 4'(DEC_MAX) : log2_i;
    smp = AW'($signed(dat_i));
    sum_d = acc_q + smp;
    win = (DEC_MAX+1)'(1) << n_q;
    last = {1'b0, cnt_q} == win - (DEC_MAX+1)'(1);
  end
  // a completed window returns to IDLE so the very next sample opens the next one
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      n_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      dat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (!en_i) begin
        state_q <= IDLE;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (vld_i) begin
        if (state_q == IDLE) begin
          n_q <= n_d;
          if (n_d == '0) begin
            dat_q <= dat_i;
            vld_q <= 1'b1;
          end else begin
            acc_q <= smp;
            cnt_q <= (DEC_MAX)'(1);
            state_q <= ACC;
          end
        end else if (last) begin
          dat_q <= DW'(sum_d >>> n_q);
          vld_q <= 1'b1;
          acc_q <= '0;
          cnt_q <= '0;
          state_q <= IDLE;
        end else begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + (DEC_MAX)'(1);
        end
      end
    end
  end
  assign dat_o = dat_q;
  assign vld_o = vld_q;
endmodule

// File: rtl/adc_cal_dec.sv
// adc_cal_dec: 3-stage offset/gain calibration with saturation feeding a decimating averager.
// Clip status/counter is built only when ADC_CLIP_DET_EN is defined.
module adc_cal_dec import adc_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int DEC_MAX = DEC_MAX_DEF
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic [15:0]   adc_dat_i,
  input  logic [DW-1:0] cal_off_i,
  input  logic [15:0]   cal_gain_i,
  input  logic [3:0]    dec_log2_i,
  input  logic          en_i,
  input  logic          clip_clr_i,
  output logic [DW-1:0] cal_dat_o,
  output logic          cal_vld_o,
  output logic [DW-1:0] dec_dat_o,
  output logic          dec_vld_o,
  output logic          clip_o,
  output logic [15:0]   clip_cnt_o
);
  localparam int PW = DW + 17;
  localparam int SH = $clog2(GAIN_ONE);
  localparam logic signed [DW:0] MAX1 = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] MIN1 = {2'b11, {(DW-1){1'b0}}};
  localparam logic signed [PW-1:0] MAXP = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINP = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [DW-1:0] x;
  logic signed [DW:0] sum1;
  logic signed [PW-1:0] p_d, p_q, sh3;
  logic [DW-1:0] s1_d, s1_q, cal_d, cal_q;
  logic [2:0] vld_q;
  logic unused_bits;
  always_comb begin
    x = {adc_dat_i[15], ~adc_dat_i[14 -: DW-1]};
    sum1 = $signed({x[DW-1], x}) + $signed({cal_off_i[DW-1], cal_off_i});
    s1_d = sum1 > MAX1 ? MAX1[DW-1:0] : sum1 < MIN1 ? MIN1[DW-1:0] : sum1[DW-1:0];
    p_d = PW'($signed(s1_q)) * PW'($signed({1'b0, cal_gain_i}));
    sh3 = p_q >>> SH;
    cal_d = sh3 > MAXP ? MAXP[DW-1:0] : sh3 < MINP ? MINP[DW-1:0] : sh3[DW-1:0];
  end
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      s1_q <= '0;
      p_q <= '0;
      cal_q <= '0;
      vld_q <= '0;
    end else begin
      s1_q <= s1_d;
      p_q <= p_d;
      cal_q <= cal_d;
      vld_q <= {vld_q[1:0], 1'b1};
    end
  end
  assign cal_dat_o = cal_q;
  assign cal_vld_o = vld_q[2];
`ifdef ADC_CLIP_DET_EN
  logic clip_ev, clip_q;
  logic [15:0] clip_cnt_q;
  assign clip_ev = sum1 > MAX1 || sum1 < MIN1 || sh3 > MAXP || sh3 < MINP;
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      clip_q <= 1'b0;
      clip_cnt_q <= '0;
    end else begin
      clip_q <= clip_ev | (clip_q & ~clip_clr_i);
      clip_cnt_q <= clip_clr_i ? {15'd0, clip_ev} : (clip_ev && clip_cnt_q != 16'hFFFF) ? clip_cnt_q + 16'd1 : clip_cnt_q;
    end
  end
  assign clip_o = clip_q;
  assign clip_cnt_o = clip_cnt_q;
  assign unused_bits = ^adc_dat_i;
`else
  assign clip_o = 1'b0;
  assign clip_cnt_o = '0;
  assign unused_bits = ^{adc_dat_i, clip_clr_i};
`endif
  adc_dec_avg #(.DW(DW), .DEC_MAX(DEC_MAX)) u_dec (
    .clk_i (adc_clk_i),
    .rstn_i(adc_rstn_i),
    .en_i  (en_i),
    .vld_i (vld_q[2]),
    .dat_i (cal_q),
    .log2_i(dec_log2_i),
    .dat_o (dec_dat_o),
    .vld_o (dec_vld_o)
  );
endmodule
